mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter and sequencer between the three memory requesters (ICache fetch, LSB load, LSB store) and the single byte-serial memory controller. Latches at most one transaction at a time, chooses the winner by fixed priority with an optional starvation guard, and discards speculative loads and fetches on a misprediction clear. Committed stores always run to completion. It also holds back I/O stores while the I/O buffer is full.

## Interface
Parameters:
- ADDR_W, 32, address width
- STARVE_LIMIT, 4, consecutive fetch losses before fetch is forced to win (guard only)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- rdy  in  1  global enable; when low, all state holds
- clr  in  1  ROB misprediction clear
- ic_req / ic_addr  in  1 / ADDR_W  fetch request (word, 4 bytes)
- ic_done / ic_data  out  1 / 32  fetch complete pulse / instruction
- ld_req / ld_addr / ld_len  in  1 / ADDR_W / 3  load request; len in bytes: 1, 2 or 4
- ld_done / ld_data  out  1 / 32  load complete pulse / zero-extended data
- st_req / st_addr / st_len / st_data  in  1 / ADDR_W / 3 / 32  committed store request
- st_done  out  1  store complete pulse
- io_buffer_full  in  1  I/O sink cannot accept a byte
- mc_valid  out  1  one-cycle start pulse to memory controller
- mc_write / mc_addr / mc_len / mc_wdata  out  1 / ADDR_W / 3 / 32  transaction descriptor, held stable from mc_valid to mc_done
- mc_done / mc_rdata  in  1 / 32  controller completion pulse / read data

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - Samples the requests.
  - Priority is st > ld > ic.
  - The winner's descriptor is latched and the state moves to ISSUE.
  - Requests are level-sensitive. A requester holds req until its done pulse.
- I/O store (addr[17:16]==2'b11) with io_buffer_full=1: the store is not selected. Load or fetch may win instead. The store is retried every idle cycle.
- ISSUE: mc_valid=1 for exactly one cycle, then the state moves to WAIT.
- WAIT:
  - On mc_done, the matching done pulse fires for one cycle.
  - ld_data/ic_data are set to mc_rdata, masked to ld_len bytes.
  - The state returns to IDLE.
- clr:
  - clr in IDLE: no grant this cycle.
  - clr in ISSUE or WAIT with a load or fetch: the state moves to DRAIN. mc_valid is still issued if in ISSUE, because the controller cannot abort mid-byte.
  - DRAIN: waits for mc_done, suppresses ld_done/ic_done, then returns to IDLE.
  - A store in flight ignores clr and completes normally, including st_done.
- clr and mc_done in the same cycle for a load or fetch: the done pulse is suppressed. The state goes directly to IDLE.
- Reset, including mid-transaction:
  - State goes to IDLE.
  - All outputs go to 0: mc_valid, mc_write, mc_addr, mc_len, mc_wdata, done pulses, data outputs.
  - Starvation counter goes to 0.
  - The downstream controller is reset by the same rst.

## Timing
- Requests sampled in IDLE at cycle N; mc_valid at N+1; WAIT from N+2.
- Done pulse in the same cycle that mc_done is seen (registered output, visible at N_done+1).
- IDLE is re-entered on the cycle after done. A back-to-back request is granted then, giving a minimum of 1 idle cycle between transactions.
- Done pulses are mutually exclusive and never exceed one cycle.

## Configuration
- MEM_ARB_STARVE_EN defined:
  - A 3-bit counter increments each grant in which ic_req=1 but fetch lost.
  - At STARVE_LIMIT, fetch wins the next IDLE grant over ld and st.
  - The counter clears on every fetch grant.
- Undefined: strict st > ld > ic priority, no counter.

## Structure
- Shared define file holds:
  - state encodings
  - LEN_BYTE/LEN_HALF/LEN_WORD (3'd1/3'd2/3'd4)
  - IO address-match constant
  - TRUE/FALSE/NULL32
- One sub-module, mem_arb_pick: combinational winner select from the requests, the I/O-full block and the starvation flag. It returns a one-hot grant.

## Test plan
- Simultaneous ld_req (0x1000, len 4) and ic_req (0x0) in IDLE -> load issued first (mc_addr=0x1000, mc_len=4), ld_done with mc_rdata; fetch issued next.
- st_req to 0x30000 with io_buffer_full=1 and ld_req pending -> load granted; store granted on the first IDLE after io_buffer_full drops; st_done once.
- clr 2 cycles after a fetch grant -> DRAIN, no ic_done on mc_done, next request granted in the following IDLE.
- clr during an in-flight store -> store completes, st_done=1 exactly once.
- With MEM_ARB_STARVE_EN, ld_req and ic_req held high -> fetch granted after 4 consecutive load grants; without the macro, fetch is never granted while ld_req=1.
- rst low while in WAIT -> next cycle all outputs 0, state IDLE, no done pulse for the aborted transaction.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, grant vector,
// access lengths, I/O address match and data-lane masking.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // One-hot winner of an IDLE arbitration round
    typedef struct packed {
        logic st;
        logic ld;
        logic ic;
    } grant_t;

    localparam logic [2:0] LEN_BYTE = 3'd1;
    localparam logic [2:0] LEN_HALF = 3'd2;
    localparam logic [2:0] LEN_WORD = 3'd4;

    // addr[17:16] == 2'b11 selects the I/O region
    localparam int unsigned IO_LSB = 16;
    localparam logic [1:0]  IO_SEL = 2'b11;

    localparam logic        TRUE   = 1'b1;
    localparam logic        FALSE  = 1'b0;
    localparam logic [31:0] NULL32 = 32'h0000_0000;

    localparam int unsigned CNT_W = 3;

    // Zero-extend the low len bytes of a read word
    function automatic logic [31:0] len_mask(input logic [31:0] d, input logic [2:0] len);
        case (len)
            LEN_BYTE: return {24'h00_0000, d[7:0]};
            LEN_HALF: return {16'h0000, d[15:0]};
            default:  return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: st > ld > ic, a blocked I/O store sits out,
// and an asserted starvation flag hands the round to a pending fetch.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   st_req,
    input  logic   ld_req,
    input  logic   ic_req,
    input  logic   st_blocked,
    input  logic   starve,
    output grant_t grant_c
);

    always_comb begin
        grant_c = '0;
        if (starve && ic_req) begin
            grant_c.ic = TRUE;
        end else if (st_req && !st_blocked) begin
            grant_c.st = TRUE;
        end else if (ld_req) begin
            grant_c.ld = TRUE;
        end else if (ic_req) begin
            grant_c.ic = TRUE;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer between fetch, load and store requesters and the byte-serial
// memory controller. Define MEM_ARB_STARVE_EN to enable the fetch starvation guard.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    output logic [31:0]       ic_data,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [2:0]        ld_len,
    output logic              ld_done,
    output logic [31:0]       ld_data,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [2:0]        st_len,
    input  logic [31:0]       st_data,
    output logic              st_done,
    input  logic              io_buffer_full,
    output logic              mc_valid,
    output logic              mc_write,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [2:0]        mc_len,
    output logic [31:0]       mc_wdata,
    input  logic              mc_done,
    input  logic [31:0]       mc_rdata
);

    state_t state;
    grant_t cur;
    grant_t grant_c;
    logic   st_blocked_c;
    logic   starve_c;
    logic   grant_ok_c;

    assign st_blocked_c = io_buffer_full && (st_addr[IO_LSB+1:IO_LSB] == IO_SEL);
    assign grant_ok_c   = rdy && (state == S_IDLE) && !clr && (|grant_c);

    mem_arb_pick u_pick (
        .st_req     (st_req),
        .ld_req     (ld_req),
        .ic_req     (ic_req),
        .st_blocked (st_blocked_c),
        .starve     (starve_c),
        .grant_c    (grant_c)
    );

`ifdef MEM_ARB_STARVE_EN
    logic [CNT_W-1:0] starve_cnt;

    assign starve_c = (starve_cnt >= CNT_W'(STARVE_LIMIT));

    // Counts grants a waiting fetch lost; saturates so it cannot wrap past the limit
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_ok_c) begin
            if (grant_c.ic) begin
                starve_cnt <= '0;
            end else if (ic_req && (starve_cnt != '1)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_starve_limit;

    assign starve_c            = FALSE;
    assign unused_starve_limit = ^STARVE_LIMIT;
`endif

    // Transaction sequencer; pulses default low every cycle, everything else holds while !rdy
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            cur      <= '0;
            mc_valid <= FALSE;
            mc_write <= FALSE;
            mc_addr  <= '0;
            mc_len   <= '0;
            mc_wdata <= NULL32;
            ic_done  <= FALSE;
            ld_done  <= FALSE;
            st_done  <= FALSE;
            ic_data  <= NULL32;
            ld_data  <= NULL32;
        end else begin
            mc_valid <= FALSE;
            ic_done  <= FALSE;
            ld_done  <= FALSE;
            st_done  <= FALSE;
            if (rdy) begin
                case (state)
                    S_IDLE: begin
                        if (grant_ok_c) begin
                            cur      <= grant_c;
                            mc_valid <= TRUE;
                            mc_write <= grant_c.st;
                            mc_addr  <= grant_c.st ? st_addr : (grant_c.ld ? ld_addr : ic_addr);
                            mc_len   <= grant_c.st ? st_len  : (grant_c.ld ? ld_len  : LEN_WORD);
                            mc_wdata <= grant_c.st ? st_data : NULL32;
                            state    <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        // The controller has already seen mc_valid; a clear can only drain it
                        state <= (clr && !cur.st) ? S_DRAIN : S_WAIT;
                    end
                    S_WAIT: begin
                        if (mc_done) begin
                            state <= S_IDLE;
                            if (cur.st) begin
                                st_done <= TRUE;
                            end else if (!clr) begin
                                if (cur.ld) begin
                                    ld_done <= TRUE;
                                    ld_data <= len_mask(mc_rdata, mc_len);
                                end else if (cur.ic) begin
                                    ic_done <= TRUE;
                                    ic_data <= mc_rdata;
                                end
                            end
                        end else if (clr && !cur.st) begin
                            state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (mc_done) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single-transaction vectors plus
// hand-written multi-cycle sequences (clear, drain, I/O hold, starvation, reset).
module tb_mem_arbiter;

    localparam int K_IC = 0;
    localparam int K_LD = 1;
    localparam int K_ST = 2;
    localparam int NV   = 8;

    typedef struct {
        logic        st;
        logic        ld;
        logic        ic;
        logic        io_full;
        logic [31:0] st_addr;
        logic [31:0] ld_addr;
        logic [31:0] ic_addr;
        logic [2:0]  st_len;
        logic [2:0]  ld_len;
        logic [31:0] st_data;
        logic [31:0] rdata;
        logic        e_write;
        logic [31:0] e_addr;
        logic [2:0]  e_len;
        logic [31:0] e_wdata;
        int          e_kind;
        logic [31:0] e_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, rdy, clr;
    logic        ic_req, ld_req, st_req;
    logic [31:0] ic_addr, ld_addr, st_addr, st_data;
    logic [2:0]  ld_len, st_len;
    logic        ic_done, ld_done, st_done;
    logic [31:0] ic_data, ld_data;
    logic        io_buffer_full;
    logic        mc_valid, mc_write, mc_done;
    logic [31:0] mc_addr, mc_wdata, mc_rdata;
    logic [2:0]  mc_len;

    mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .clr            (clr),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .ic_done        (ic_done),
        .ic_data        (ic_data),
        .ld_req         (ld_req),
        .ld_addr        (ld_addr),
        .ld_len         (ld_len),
        .ld_done        (ld_done),
        .ld_data        (ld_data),
        .st_req         (st_req),
        .st_addr        (st_addr),
        .st_len         (st_len),
        .st_data        (st_data),
        .st_done        (st_done),
        .io_buffer_full (io_buffer_full),
        .mc_valid       (mc_valid),
        .mc_write       (mc_write),
        .mc_addr        (mc_addr),
        .mc_len         (mc_len),
        .mc_wdata       (mc_wdata),
        .mc_done        (mc_done),
        .mc_rdata       (mc_rdata)
    );

    always #5 clk = ~clk;

    // Memory controller model: mc_done mc_lat+1 cycles after it accepts mc_valid
    int          mc_lat;
    int          mc_cnt;
    logic        mc_busy;
    logic [31:0] mem_rdata;

    always @(posedge clk) begin
        mc_done <= 1'b0;
        if (!rst) begin
            mc_busy  <= 1'b0;
            mc_cnt   <= 0;
            mc_rdata <= 32'h0;
        end else if (mc_busy) begin
            if (mc_cnt == 0) begin
                mc_done  <= 1'b1;
                mc_rdata <= mem_rdata;
                mc_busy  <= 1'b0;
            end else begin
                mc_cnt <= mc_cnt - 1;
            end
        end else if (mc_valid) begin
            mc_busy <= 1'b1;
            mc_cnt  <= mc_lat;
        end
    end

    int          n_chk, n_pass, cyc;
    int          n_issue, n_ic, n_ld, n_st;
    int          last_kind, issue_cyc, done_cyc, mcdone_cyc;
    int          excl_err, width_err;
    logic        prev_ic, prev_ld, prev_st, hold_reqs;
    logic        last_write;
    logic [31:0] last_addr, last_wdata;
    logic [2:0]  last_len;
    logic [31:0] iss_q[$];
    vec_t        vecs[NV];
    vec_t        v;
    int          base, base2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // One cycle: observe outputs at the falling edge; requesters drop req on their done
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mc_valid) begin
            n_issue++;
            iss_q.push_back(mc_addr);
            last_write = mc_write;
            last_addr  = mc_addr;
            last_len   = mc_len;
            last_wdata = mc_wdata;
            issue_cyc  = cyc;
        end
        if (mc_done) mcdone_cyc = cyc;
        if ((int'(ic_done) + int'(ld_done) + int'(st_done)) > 1) excl_err++;
        if ((ic_done && prev_ic) || (ld_done && prev_ld) || (st_done && prev_st)) width_err++;
        prev_ic = ic_done;
        prev_ld = ld_done;
        prev_st = st_done;
        if (ic_done) begin n_ic++; last_kind = K_IC; done_cyc = cyc; if (!hold_reqs) ic_req = 1'b0; end
        if (ld_done) begin n_ld++; last_kind = K_LD; done_cyc = cyc; if (!hold_reqs) ld_req = 1'b0; end
        if (st_done) begin n_st++; last_kind = K_ST; done_cyc = cyc; if (!hold_reqs) st_req = 1'b0; end
    endtask

    task automatic wait_issue(input int budget, input string name);
        int b;
        b = n_issue;
        for (int i = 0; i < budget && n_issue == b; i++) tick();
        chk(name, 32'(n_issue != b), 32'd1);
    endtask

    task automatic wait_done(input int budget, input string name);
        int b;
        b = n_ic + n_ld + n_st;
        for (int i = 0; i < budget && (n_ic + n_ld + n_st) == b; i++) tick();
        chk(name, 32'((n_ic + n_ld + n_st) != b), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //             st    ld    ic    io    st_addr        ld_addr        ic_addr        stl   ldl   st_data        rdata           wr    e_addr         e_len e_wdata        kind  e_data
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0000_1000, 32'h0,         3'd0, 3'd4, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0000_1000, 3'd4, 32'h0,         K_LD, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         32'h0000_0040, 3'd0, 3'd0, 32'h0,         32'h0010_0093, 1'b0, 32'h0000_0040, 3'd4, 32'h0,         K_IC, 32'h0010_0093};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_2003, 32'h0,         3'd0, 3'd1, 32'h0,         32'hAABB_CCDD, 1'b0, 32'h0000_2003, 3'd1, 32'h0,         K_LD, 32'h0000_00DD};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0000_2002, 32'h0000_0080, 3'd0, 3'd2, 32'h0,         32'h1122_3344, 1'b0, 32'h0000_2002, 3'd2, 32'h0,         K_LD, 32'h0000_3344};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0000_0600, 32'h0000_0700, 3'd4, 3'd4, 32'hCAFE_F00D, 32'h0,         1'b1, 32'h0000_0500, 3'd4, 32'hCAFE_F00D, K_ST, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0003_0000, 32'h0000_0100, 32'h0,         3'd1, 3'd1, 32'h0000_00AB, 32'h1234_5655, 1'b0, 32'h0000_0100, 3'd1, 32'h0,         K_LD, 32'h0000_0055};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0003_0004, 32'h0,         32'h0,         3'd1, 3'd0, 32'h0000_00AB, 32'h0,         1'b1, 32'h0003_0004, 3'd1, 32'h0000_00AB, K_ST, 32'h0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0002_0000, 32'h0000_0100, 32'h0,         3'd2, 3'd4, 32'h0000_BEEF, 32'h0,         1'b1, 32'h0002_0000, 3'd2, 32'h0000_BEEF, K_ST, 32'h0};

        rst = 1'b0; rdy = 1'b1; clr = 1'b0; io_buffer_full = 1'b0;
        ic_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        ic_addr = 32'h0; ld_addr = 32'h0; st_addr = 32'h0; st_data = 32'h0;
        ld_len = 3'd0; st_len = 3'd0; mc_lat = 1; mem_rdata = 32'h0;
        hold_reqs = 1'b0; prev_ic = 1'b0; prev_ld = 1'b0; prev_st = 1'b0;
        last_write = 1'b0; last_addr = 32'h0; last_wdata = 32'h0; last_len = 3'd0;

        // Reset state
        repeat (3) tick();
        chk("reset mc_valid", 32'(mc_valid), 32'd0);
        chk("reset mc_addr", mc_addr, 32'h0);
        chk("reset dones", 32'({ic_done, ld_done, st_done}), 32'd0);
        chk("reset data", ic_data | ld_data, 32'h0);
        rst = 1'b1;
        tick();

        // Load beats fetch, then the still-pending fetch is issued one idle cycle after ld_done
        ld_addr = 32'h0000_1000; ld_len = 3'd4; ic_addr = 32'h0; mem_rdata = 32'h0BAD_F00D;
        ld_req = 1'b1; ic_req = 1'b1;
        wait_issue(8, "s1 first issue");
        chk("s1 first addr", last_addr, 32'h0000_1000);
        chk("s1 first len", 32'(last_len), 32'd4);
        wait_done(20, "s1 load done");
        chk("s1 load kind", 32'(last_kind), 32'(K_LD));
        chk("s1 ld_data", ld_data, 32'h0BAD_F00D);
        wait_issue(8, "s1 fetch issue");
        chk("s1 fetch addr", last_addr, 32'h0);
        chk("s1 idle gap", 32'(issue_cyc - done_cyc), 32'd1);
        wait_done(20, "s1 fetch done");
        chk("s1 fetch kind", 32'(last_kind), 32'(K_IC));
        chk("s1 ic_data", ic_data, 32'h0BAD_F00D);
        tick();

        // Table of single-winner transactions
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            st_addr = v.st_addr; ld_addr = v.ld_addr; ic_addr = v.ic_addr;
            st_len = v.st_len; ld_len = v.ld_len; st_data = v.st_data;
            io_buffer_full = v.io_full; mem_rdata = v.rdata;
            st_req = v.st; ld_req = v.ld; ic_req = v.ic;
            wait_issue(8, $sformatf("v%0d issue", i));
            if (v.e_kind != K_ST) st_req = 1'b0;
            if (v.e_kind != K_LD) ld_req = 1'b0;
            if (v.e_kind != K_IC) ic_req = 1'b0;
            chk($sformatf("v%0d mc_write", i), 32'(last_write), 32'(v.e_write));
            chk($sformatf("v%0d mc_addr", i), last_addr, v.e_addr);
            chk($sformatf("v%0d mc_len", i), 32'(last_len), 32'(v.e_len));
            chk($sformatf("v%0d mc_wdata", i), last_wdata, v.e_wdata);
            wait_done(20, $sformatf("v%0d done", i));
            chk($sformatf("v%0d done kind", i), 32'(last_kind), 32'(v.e_kind));
            if (v.e_kind == K_LD) chk($sformatf("v%0d ld_data", i), ld_data, v.e_data);
            if (v.e_kind == K_IC) chk($sformatf("v%0d ic_data", i), ic_data, v.e_data);
            st_req = 1'b0; ld_req = 1'b0; ic_req = 1'b0; io_buffer_full = 1'b0;
            tick(); tick();
        end

        // I/O store held back while the buffer is full, granted on the first idle after it drains
        io_buffer_full = 1'b1;
        st_addr = 32'h0003_0000; st_len = 3'd1; st_data = 32'h0000_005A;
        ld_addr = 32'h0000_0100; ld_len = 3'd1; mem_rdata = 32'h0000_0042;
        st_req = 1'b1; ld_req = 1'b1;
        wait_issue(8, "io load issue");
        chk("io load addr", last_addr, 32'h0000_0100);
        wait_done(20, "io load done");
        chk("io load kind", 32'(last_kind), 32'(K_LD));
        base = n_issue;
        repeat (4) tick();
        chk("io store held", 32'(n_issue - base), 32'd0);
        base2 = n_st;
        io_buffer_full = 1'b0;
        base = cyc;
        wait_issue(8, "io store issue");
        chk("io retry latency", 32'(issue_cyc - base), 32'd1);
        chk("io store addr", last_addr, 32'h0003_0000);
        chk("io store write", 32'(last_write), 32'd1);
        wait_done(20, "io store done");
        repeat (6) tick();
        chk("io st_done once", 32'(n_st - base2), 32'd1);

        // Clear two cycles after a fetch grant: drain without ic_done, then serve the next request
        mc_lat = 4; ic_addr = 32'h0000_0400; mem_rdata = 32'h1111_2222;
        base2 = n_ic;
        ic_req = 1'b1;
        wait_issue(8, "clr fetch issue");
        tick();
        clr = 1'b1; ic_req = 1'b0;
        tick();
        clr = 1'b0;
        ld_addr = 32'h0000_0900; ld_len = 3'd4; ld_req = 1'b1;
        wait_issue(30, "clr next issue");
        chk("clr next addr", last_addr, 32'h0000_0900);
        chk("clr next after drain", 32'(issue_cyc - mcdone_cyc), 32'd2);
        chk("clr no ic_done", 32'(n_ic - base2), 32'd0);
        wait_done(30, "clr next done");
        chk("clr next kind", 32'(last_kind), 32'(K_LD));
        tick();

        // Clear during an in-flight store has no effect on it
        mc_lat = 3; st_addr = 32'h0000_0800; st_len = 3'd4; st_data = 32'h0102_0304;
        base2 = n_st;
        st_req = 1'b1;
        wait_issue(8, "clr store issue");
        clr = 1'b1;
        tick(); tick();
        clr = 1'b0;
        wait_done(30, "clr store done");
        chk("clr store kind", 32'(last_kind), 32'(K_ST));
        repeat (5) tick();
        chk("clr st_done once", 32'(n_st - base2), 32'd1);

        // Clear in IDLE blocks the grant; rdy low freezes the arbiter
        mc_lat = 1; ic_addr = 32'h0000_0044; base = n_issue;
        clr = 1'b1; ic_req = 1'b1;
        repeat (3) tick();
        chk("clr idle no grant", 32'(n_issue - base), 32'd0);
        clr = 1'b0;
        wait_issue(3, "clr idle release");
        wait_done(20, "clr idle done");
        rdy = 1'b0; ld_addr = 32'h0000_0104; ld_len = 3'd4; ld_req = 1'b1; base = n_issue;
        repeat (3) tick();
        chk("rdy low no grant", 32'(n_issue - base), 32'd0);
        rdy = 1'b1;
        wait_issue(3, "rdy high issue");
        wait_done(20, "rdy high done");
        tick();

        // Load and fetch held high together
        mc_lat = 0; mem_rdata = 32'h0000_1234;
        ld_addr = 32'h0000_0100; ld_len = 3'd4; ic_addr = 32'h0000_0200;
        hold_reqs = 1'b1; base = n_issue;
        ld_req = 1'b1; ic_req = 1'b1;
        for (int i = 0; i < 200 && n_issue < base + 6; i++) tick();
        chk("starve six issues", 32'(n_issue >= base + 6), 32'd1);
        for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_STARVE_EN
            chk($sformatf("starve grant %0d", k), iss_q[base + k], (k == 4) ? 32'h0000_0200 : 32'h0000_0100);
`else
            chk($sformatf("strict grant %0d", k), iss_q[base + k], 32'h0000_0100);
`endif
        end
        hold_reqs = 1'b0; ld_req = 1'b0; ic_req = 1'b0;
        repeat (20) tick();

        // Reset in WAIT aborts the load with every output cleared
        mc_lat = 6; ld_addr = 32'h0000_0300; ld_len = 3'd4; mem_rdata = 32'h0000_0077;
        ld_req = 1'b1;
        wait_issue(8, "rst load issue");
        tick();
        base2 = n_ld;
        rst = 1'b0;
        tick();
        chk("rst mc_valid", 32'(mc_valid), 32'd0);
        chk("rst mc_write", 32'(mc_write), 32'd0);
        chk("rst mc_addr", mc_addr, 32'h0);
        chk("rst mc_len", 32'(mc_len), 32'd0);
        chk("rst mc_wdata", mc_wdata, 32'h0);
        chk("rst dones", 32'({ic_done, ld_done, st_done}), 32'd0);
        chk("rst ld_data", ld_data, 32'h0);
        chk("rst ic_data", ic_data, 32'h0);
        rst = 1'b1; ld_req = 1'b0; base = n_issue;
        repeat (10) tick();
        chk("rst no ld_done", 32'(n_ld - base2), 32'd0);
        chk("rst no issue", 32'(n_issue - base), 32'd0);
        mc_lat = 1; ic_addr = 32'h0000_0048; ic_req = 1'b1;
        wait_issue(3, "rst idle grant");
        chk("rst idle addr", last_addr, 32'h0000_0048);
        wait_done(20, "rst idle done");
        tick();

        chk("done exclusive", 32'(excl_err), 32'd0);
        chk("done one cycle", 32'(width_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
